// File: rtl/wfr_axi_pkg.sv
// Shared encodings for the waveform-recorder AXI write arbiter.
package wfr_axi_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } arbState_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam int unsigned BEAT_CNT_W = 8;

endpackage

// File: rtl/wfr_axi_write_arbiter_rr_priority_picker.sv
// Round-robin winner search starting one past the previously granted index.
module rr_priority_picker #(
  parameter int unsigned N = 4,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] winner,
  output logic          found
);

  // Walk from farthest to nearest so the closest requester after 'last' wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = int'(N); k >= 1; k--) begin
      if (req[IW'((int'(last) + k) % int'(N))]) begin
        winner = IW'((int'(last) + k) % int'(N));
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wfr_axi_write_arbiter.sv
// Shares one AXI write port among several write-only waveform recorders,
// one whole burst (AW, W beats, B) per grant in round-robin order.
module wfr_axi_write_arbiter
  import wfr_axi_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 128
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [NUM_MASTERS*AXI_ADDR_WIDTH-1:0]     m_AWADDR,
  input  logic [NUM_MASTERS*8-1:0]                  m_AWLEN,
  input  logic [NUM_MASTERS*3-1:0]                  m_AWSIZE,
  input  logic [NUM_MASTERS-1:0]                    m_AWVALID,
  output logic [NUM_MASTERS-1:0]                    m_AWREADY,
  input  logic [NUM_MASTERS*AXI_DATA_WIDTH-1:0]     m_WDATA,
  input  logic [NUM_MASTERS*AXI_DATA_WIDTH/8-1:0]   m_WSTRB,
  input  logic [NUM_MASTERS-1:0]                    m_WLAST,
  input  logic [NUM_MASTERS-1:0]                    m_WVALID,
  output logic [NUM_MASTERS-1:0]                    m_WREADY,
  output logic [1:0]                                m_BRESP,
  output logic [NUM_MASTERS-1:0]                    m_BVALID,
  output logic [AXI_ADDR_WIDTH-1:0]                 s_AWADDR,
  output logic [7:0]                                s_AWLEN,
  output logic [2:0]                                s_AWSIZE,
  output logic [1:0]                                s_AWBURST,
  output logic                                      s_AWVALID,
  input  logic                                      s_AWREADY,
  output logic [AXI_DATA_WIDTH-1:0]                 s_WDATA,
  output logic [AXI_DATA_WIDTH/8-1:0]               s_WSTRB,
  output logic                                      s_WLAST,
  output logic                                      s_WVALID,
  input  logic                                      s_WREADY,
  input  logic [1:0]                                s_BRESP,
  input  logic                                      s_BVALID,
  output logic                                      s_BREADY,
  output logic [$clog2(NUM_MASTERS)-1:0]            grant,
  output logic                                      busy,
  output logic [NUM_MASTERS-1:0]                    protoErr
);

  localparam int unsigned IW     = $clog2(NUM_MASTERS);
  localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;

  arbState_t                  state, stateNext;
  logic [IW-1:0]              grantNext, lastGrant, lastNext, winner;
  logic                       found;
  logic [BEAT_CNT_W-1:0]      beatCnt, beatCntNext, winLen;
  logic [NUM_MASTERS-1:0]     protoErrNext;
  logic                       lastBeat;

  logic [AXI_ADDR_WIDTH-1:0]  gAwAddr;
  logic [7:0]                 gAwLen;
  logic [2:0]                 gAwSize;
  logic                       gAwValid;
  logic [AXI_DATA_WIDTH-1:0]  gWData;
  logic [STRB_W-1:0]          gWStrb;
  logic                       gWLast;
  logic                       gWValid;

  rr_priority_picker #(.N(NUM_MASTERS)) uPicker (
    .req    (m_AWVALID),
    .last   (lastGrant),
    .winner (winner),
    .found  (found)
  );

  // Select the granted master's channels, plus the arbitration winner's burst length.
  always_comb begin
    gAwAddr  = '0;
    gAwLen   = '0;
    gAwSize  = '0;
    gAwValid = 1'b0;
    gWData   = '0;
    gWStrb   = '0;
    gWLast   = 1'b0;
    gWValid  = 1'b0;
    winLen   = '0;
    for (int i = 0; i < int'(NUM_MASTERS); i++) begin
      if (grant == IW'(i)) begin
        gAwAddr  = m_AWADDR[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
        gAwLen   = m_AWLEN[i*8 +: 8];
        gAwSize  = m_AWSIZE[i*3 +: 3];
        gAwValid = m_AWVALID[i];
        gWData   = m_WDATA[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
        gWStrb   = m_WSTRB[i*STRB_W +: STRB_W];
        gWLast   = m_WLAST[i];
        gWValid  = m_WVALID[i];
      end
      if (winner == IW'(i)) begin
        winLen = m_AWLEN[i*8 +: 8];
      end
    end
  end

  assign s_AWADDR  = gAwAddr;
  assign s_AWLEN   = gAwLen;
  assign s_AWSIZE  = gAwSize;
  assign s_AWBURST = AXI_BURST_INCR;
  assign s_WDATA   = gWData;
  assign s_WSTRB   = gWStrb;
  assign m_BRESP   = s_BRESP;
  assign busy      = (state != S_IDLE);
  assign lastBeat  = (beatCnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      grant     <= '0;
      lastGrant <= IW'(NUM_MASTERS - 1);
      beatCnt   <= '0;
      protoErr  <= '0;
    end else begin
      state     <= stateNext;
      grant     <= grantNext;
      lastGrant <= lastNext;
      beatCnt   <= beatCntNext;
      protoErr  <= protoErrNext;
    end
  end

  // Next state and handshake routing; the burst always ends on the beat counter.
  always_comb begin
    stateNext    = state;
    grantNext    = grant;
    lastNext     = lastGrant;
    beatCntNext  = beatCnt;
    protoErrNext = protoErr;
    s_AWVALID    = 1'b0;
    s_WVALID     = 1'b0;
    s_WLAST      = 1'b0;
    s_BREADY     = 1'b0;
    m_AWREADY    = '0;
    m_WREADY     = '0;
    m_BVALID     = '0;

    case (state)
      S_IDLE: begin
        if (found) begin
          grantNext   = winner;
          beatCntNext = winLen;
          stateNext   = S_ADDR;
        end
      end
      S_ADDR: begin
        s_AWVALID        = gAwValid;
        m_AWREADY[grant] = s_AWREADY;
        if (gAwValid && s_AWREADY) begin
          stateNext = S_DATA;
        end
      end
      S_DATA: begin
        s_WVALID        = gWValid;
        s_WLAST         = lastBeat;
        m_WREADY[grant] = s_WREADY;
        if (gWValid && s_WREADY) begin
          if (gWLast != lastBeat) begin
            protoErrNext[grant] = 1'b1;
          end
          if (lastBeat) begin
            stateNext = S_RESP;
          end else begin
            beatCntNext = beatCnt - BEAT_CNT_W'(1);
          end
        end
      end
      S_RESP: begin
        s_BREADY        = 1'b1;
        m_BVALID[grant] = s_BVALID;
        if (s_BVALID) begin
          lastNext  = grant;
          stateNext = S_IDLE;
        end
      end
      default: stateNext = S_IDLE;
    endcase
  end

endmodule
